// File: rtl/sosu_pkg.sv
// rtl/sosu_pkg.sv - shared widths and sweep FSM states for the sosu prime scanner
package sosu_pkg;

  localparam int SOSU_W  = 4;
  localparam int SOSU_CW = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    EMIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/sosu_scan_if.sv
// rtl/sosu_scan_if.sv - control, status and prime stream bundle of the sweep engine
interface sosu_scan_if import sosu_pkg::*; #(
  parameter int W  = SOSU_W,
  parameter int CW = SOSU_CW
);

  logic          start;
  logic [W-1:0]  lo;
  logic [W-1:0]  hi;
  logic          busy;
  logic          done;
  logic          p_valid;
  logic          p_ready;
  logic [W-1:0]  p_data;
  logic [CW-1:0] p_count;
  logic [W-1:0]  cand;

  modport master (
    output start, lo, hi, p_ready,
    input  busy, done, p_valid, p_data, p_count, cand
  );

  modport slave (
    input  start, lo, hi, p_ready,
    output busy, done, p_valid, p_data, p_count, cand
  );

endinterface

// File: rtl/sosu.sv
// rtl/sosu.sv - combinational 4-bit prime detector
module sosu import sosu_pkg::*; (
  input  logic [SOSU_W-1:0] a,
  output logic              y
);

  always_comb begin
    y = 1'b0;
    case (a)
      4'd2, 4'd3, 4'd5, 4'd7, 4'd11, 4'd13: y = 1'b1;
      default:                              y = 1'b0;
    endcase
  end

endmodule

// File: rtl/sosu_scan.sv
// rtl/sosu_scan.sv - sweeps [lo, hi] through sosu and streams every prime found
module sosu_scan import sosu_pkg::*; #(
  parameter int W  = SOSU_W,
  parameter int CW = SOSU_CW
) (
  input  logic         clk,
  input  logic         rst_n,
  sosu_scan_if.slave   bus
);

  state_t        state_q, state_d;
  logic [W-1:0]  cand_q, cand_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [W-1:0]  p_data_q, p_data_d;
  logic          p_valid_q, p_valid_d;
  logic [CW-1:0] p_count_q, p_count_d;
  logic          busy_q, busy_d;
  logic          is_prime;

  sosu sosu_1 (
    .a (cand_q),
    .y (is_prime)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q    <= '0;
      hi_q      <= '0;
      p_data_q  <= '0;
      p_valid_q <= 1'b0;
      p_count_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      cand_q    <= cand_d;
      hi_q      <= hi_d;
      p_data_q  <= p_data_d;
      p_valid_q <= p_valid_d;
      p_count_q <= p_count_d;
      busy_q    <= busy_d;
    end
  end

  // The cand==hi test always precedes the increment, so hi=15 ends without wrapping.
  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    hi_d      = hi_q;
    p_data_d  = p_data_q;
    p_valid_d = p_valid_q;
    p_count_d = p_count_q;
    busy_d    = busy_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          hi_d      = bus.hi;
          cand_d    = bus.lo;
          p_count_d = '0;
          busy_d    = 1'b1;
          state_d   = (bus.lo > bus.hi) ? DONE : CHECK;
        end
      end
      CHECK: begin
        if (is_prime) begin
          p_data_d  = cand_q;
          p_valid_d = 1'b1;
          p_count_d = p_count_q + 1'b1;
          state_d   = EMIT;
        end else if (cand_q == hi_q) begin
          state_d = DONE;
        end else begin
          cand_d = cand_q + 1'b1;
        end
      end
      EMIT: begin
        if (bus.p_ready) begin
          p_valid_d = 1'b0;
          if (cand_q == hi_q) begin
            state_d = DONE;
          end else begin
            cand_d  = cand_q + 1'b1;
            state_d = CHECK;
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy    = busy_q;
  assign bus.done    = (state_q == DONE);
  assign bus.p_valid = p_valid_q;
  assign bus.p_data  = p_data_q;
  assign bus.p_count = p_count_q;
  assign bus.cand    = cand_q;

endmodule

// File: tb/tb_sosu_scan.sv
// tb/tb_sosu_scan.sv - directed bench for the sosu_scan sweep engine
module tb_sosu_scan;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  logic [3:0] got[$];
  int         done_cnt;
  int         done_at;
  bit         cand_bad;
  int         stall_cyc;
  bit         stall_bad;
  bit         timed_out;

  sosu_scan_if bus ();

  sosu_scan dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one sweep from a negedge, recording emitted primes and the done timing.
  task automatic sweep(input logic [3:0] l, input logic [3:0] h, input int stall, input int inj);
    int         cyc;
    int         stall_left;
    bit         stalling;
    logic [3:0] held;
    logic [3:0] prev;
    got.delete();
    done_cnt = 0; done_at = 0; cand_bad = 0; stall_cyc = 0; stall_bad = 0; timed_out = 0;
    stall_left = stall; stalling = 0; held = '0; prev = l;
    bus.lo = l; bus.hi = h; bus.start = 1'b1; bus.p_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    while (1) begin
      if (inj > 0 && cyc == inj) begin
        bus.start = 1'b1; bus.lo = 4'd0; bus.hi = 4'd3;
      end else if (inj > 0 && cyc == inj + 1) begin
        bus.start = 1'b0;
      end
      if (bus.p_valid && stall_left > 0) begin
        if (!stalling) held = bus.p_data;
        stalling = 1;
        if (bus.p_data !== held) stall_bad = 1;
        bus.p_ready = 1'b0;
        stall_left--;
        stall_cyc++;
      end else begin
        if (stalling && stall_left > 0 && !bus.p_valid) stall_bad = 1;
        bus.p_ready = 1'b1;
      end
      if (bus.p_valid && bus.p_ready) got.push_back(bus.p_data);
      if (bus.done) begin
        done_cnt++;
        if (done_at == 0) done_at = cyc;
      end
      if (l <= h && bus.busy) begin
        if (bus.cand < l || bus.cand > h || bus.cand < prev) cand_bad = 1;
        prev = bus.cand;
      end
      if (done_at != 0 && cyc >= done_at + 3) break;
      if (cyc >= 200) begin
        timed_out = 1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.p_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_ctrl busy=%b done=%b p_valid=%b exp 0 0 0", bus.busy, bus.done, bus.p_valid);
    end
    n_cmp++;
    if (bus.p_data !== 4'd0 || bus.p_count !== 5'd0 || bus.cand !== 4'd0) begin
      n_bad++; $display("FAIL reset_data p_data=%0d p_count=%0d cand=%0d exp 0 0 0", bus.p_data, bus.p_count, bus.cand);
    end
    n_cmp++;
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_bad++; $display("FAIL idle_after_reset busy=%b done=%b exp 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_full_sweep();
    logic [3:0] exp_q[$] = '{4'd2, 4'd3, 4'd5, 4'd7, 4'd11, 4'd13};
    sweep(4'd0, 4'd15, 0, 0);
    n_cmp++;
    if (timed_out) begin n_bad++; $display("FAIL full_timeout got=1 exp=0"); end
    n_cmp++;
    if (got.size() !== exp_q.size()) begin
      n_bad++; $display("FAIL full_nprimes got=%0d exp=%0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got.size()) begin
        n_cmp++;
        if (got[i] !== exp_q[i]) begin n_bad++; $display("FAIL full_data[%0d] got=%0d exp=%0d", i, got[i], exp_q[i]); end
      end
    end
    n_cmp++;
    if (bus.p_count !== 5'd6) begin n_bad++; $display("FAIL full_count got=%0d exp=6", bus.p_count); end
    n_cmp++;
    if (done_at !== 23) begin n_bad++; $display("FAIL full_done_latency got=%0d exp=23", done_at); end
    n_cmp++;
    if (done_cnt !== 1) begin n_bad++; $display("FAIL full_done_pulses got=%0d exp=1", done_cnt); end
    n_cmp++;
    if (cand_bad) begin n_bad++; $display("FAIL full_cand_range got=out_of_range exp=monotonic_0_to_15"); end
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.p_data !== 4'd13) begin
      n_bad++; $display("FAIL full_after busy=%b p_data=%0d exp busy=0 p_data=13", bus.busy, bus.p_data);
    end
  endtask

  task automatic test_backpressure();
    sweep(4'd4, 4'd7, 5, 0);
    n_cmp++;
    if (got.size() !== 2) begin
      n_bad++; $display("FAIL bp_nprimes got=%0d exp=2", got.size());
    end else begin
      n_cmp++;
      if (got[0] !== 4'd5 || got[1] !== 4'd7) begin
        n_bad++; $display("FAIL bp_data got=%0d,%0d exp=5,7", got[0], got[1]);
      end
    end
    n_cmp++;
    if (stall_cyc !== 5 || stall_bad) begin
      n_bad++; $display("FAIL bp_hold stall_cycles=%0d unstable=%0d exp 5 0", stall_cyc, stall_bad);
    end
    n_cmp++;
    if (bus.p_count !== 5'd2) begin n_bad++; $display("FAIL bp_count got=%0d exp=2", bus.p_count); end
    n_cmp++;
    if (done_cnt !== 1 || timed_out) begin n_bad++; $display("FAIL bp_done pulses=%0d timeout=%0d exp 1 0", done_cnt, timed_out); end
  endtask

  task automatic test_degenerate();
    sweep(4'd13, 4'd13, 0, 0);
    n_cmp++;
    if (got.size() !== 1 || (got.size() == 1 && got[0] !== 4'd13)) begin
      n_bad++; $display("FAIL single13_data n=%0d exp one value 13", got.size());
    end
    n_cmp++;
    if (bus.p_count !== 5'd1 || done_at !== 3) begin
      n_bad++; $display("FAIL single13_count p_count=%0d done_at=%0d exp 1 3", bus.p_count, done_at);
    end
    sweep(4'd9, 4'd9, 0, 0);
    n_cmp++;
    if (got.size() !== 0 || bus.p_count !== 5'd0) begin
      n_bad++; $display("FAIL single9 n=%0d p_count=%0d exp 0 0", got.size(), bus.p_count);
    end
    n_cmp++;
    if (done_at !== 2 || done_cnt !== 1) begin
      n_bad++; $display("FAIL single9_done done_at=%0d pulses=%0d exp 2 1", done_at, done_cnt);
    end
    sweep(4'd10, 4'd3, 0, 0);
    n_cmp++;
    if (got.size() !== 0 || bus.p_count !== 5'd0) begin
      n_bad++; $display("FAIL inverted n=%0d p_count=%0d exp 0 0", got.size(), bus.p_count);
    end
    n_cmp++;
    if (done_at !== 1 || done_cnt !== 1) begin
      n_bad++; $display("FAIL inverted_done done_at=%0d pulses=%0d exp 1 1", done_at, done_cnt);
    end
  endtask

  task automatic test_start_while_busy();
    sweep(4'd8, 4'd15, 0, 3);
    n_cmp++;
    if (got.size() !== 2) begin
      n_bad++; $display("FAIL busy_start_n got=%0d exp=2", got.size());
    end else begin
      n_cmp++;
      if (got[0] !== 4'd11 || got[1] !== 4'd13) begin
        n_bad++; $display("FAIL busy_start_data got=%0d,%0d exp=11,13", got[0], got[1]);
      end
    end
    n_cmp++;
    if (bus.p_count !== 5'd2 || done_at !== 11 || cand_bad) begin
      n_bad++; $display("FAIL busy_start_count p_count=%0d done_at=%0d cand_bad=%0d exp 2 11 0", bus.p_count, done_at, cand_bad);
    end
  endtask

  task automatic test_reset_mid_op();
    int k;
    bit seen_done;
    bus.lo = 4'd4; bus.hi = 4'd7; bus.p_ready = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    k = 0;
    while (!bus.p_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (bus.p_valid !== 1'b1 || bus.p_data !== 4'd5 || bus.p_count !== 5'd1) begin
      n_bad++; $display("FAIL rst_pre p_valid=%b p_data=%0d p_count=%0d exp 1 5 1", bus.p_valid, bus.p_data, bus.p_count);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.p_valid !== 1'b0 || bus.busy !== 1'b0 || bus.p_count !== 5'd0 || bus.cand !== 4'd0) begin
      n_bad++; $display("FAIL rst_async p_valid=%b busy=%b p_count=%0d cand=%0d exp 0 0 0 0",
                        bus.p_valid, bus.busy, bus.p_count, bus.cand);
    end
    seen_done = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.done) seen_done = 1;
    end
    rst_n = 1'b1;
    bus.p_ready = 1'b1;
    @(negedge clk);
    if (bus.done) seen_done = 1;
    n_cmp++;
    if (seen_done) begin n_bad++; $display("FAIL rst_no_done got=1 exp=0"); end
    sweep(4'd0, 4'd3, 0, 0);
    n_cmp++;
    if (got.size() !== 2) begin
      n_bad++; $display("FAIL rst_after_n got=%0d exp=2", got.size());
    end else begin
      n_cmp++;
      if (got[0] !== 4'd2 || got[1] !== 4'd3) begin
        n_bad++; $display("FAIL rst_after_data got=%0d,%0d exp=2,3", got[0], got[1]);
      end
    end
    n_cmp++;
    if (bus.p_count !== 5'd2) begin n_bad++; $display("FAIL rst_after_count got=%0d exp=2", bus.p_count); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.lo = '0;
    bus.hi = '0;
    bus.p_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_full_sweep();
    test_backpressure();
    test_degenerate();
    test_start_while_busy();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
